// File: rtl/tpm_clk_ctrl.sv
// tpm_clk_ctrl
//   Sequences the TPM-facing clock (ja[4]). The controller waits for the
//   upstream clock generator to hold lock, then produces a glitch-free
//   divided clock from clk. The clock can be stopped, free-running, or a
//   counted burst of N cycles. Commands use a valid/ready handshake.
//
// Ports
//   clk         system clock (clock-wizard output)
//   rst_n       asynchronous, active-low reset
//   locked      clock-generator lock status, synchronous to clk
//   cmd_valid   command present
//   cmd_ready   controller accepts a command this cycle
//   cmd_op      0=STOP 1=RUN 2=BURST 3=SETDIV
//   cmd_arg     BURST: cycle count N; SETDIV: divisor in [DIV_W-1:0]
//   tpm_clk     generated clock, registered
//   busy        high in RUN, BURST, STOPPING
//   burst_done  one-cycle pulse when a burst completes
//   cmd_err     one-cycle pulse when an accepted command is rejected
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_LOCK  | counting consecutive locked cycles, clock held low
// IDLE       | locked, clock low, any command accepted
// RUN        | free-running divided clock
// BURST      | counted burst in progress, commands held off
// STOPPING   | finishing the current high phase after a STOP
module tpm_clk_ctrl #(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 16,
  parameter int LOCK_WAIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  output logic             tpm_clk,
  output logic             busy,
  output logic             burst_done,
  output logic             cmd_err
);

  localparam int LCK_W = $clog2(LOCK_WAIT + 1);

  localparam logic [1:0] OP_STOP   = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_BURST  = 2'd2;
  localparam logic [1:0] OP_SETDIV = 2'd3;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDLE,
    S_RUN,
    S_BURST,
    S_STOPPING
  } state_t;

  state_t             state, state_nxt;
  logic               tpm_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [LCK_W-1:0]   lock_cnt, lock_nxt;
  logic [CNT_W-1:0]   burst_cnt, burst_nxt;
  logic [DIV_W-1:0]   phase_cnt, phase_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic               accept;
  logic               phase_end;

  // A command arriving while lock is being lost is not taken, so lock loss
  // always wins over acceptance.
  assign cmd_ready = locked & ((state == S_IDLE) | (state == S_RUN));
  assign busy      = (state == S_RUN) | (state == S_BURST) | (state == S_STOPPING);
  assign accept    = cmd_valid & cmd_ready;

  // Phase timer is a down-counter; zero means the current phase ends at
  // this edge. It is parked at zero in IDLE so the first high phase starts
  // one edge after the command is accepted.
  assign phase_end = (phase_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_LOCK;
      tpm_clk    <= 1'b0;
      div        <= '0;
      lock_cnt   <= '0;
      burst_cnt  <= '0;
      phase_cnt  <= '0;
      burst_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tpm_clk    <= tpm_nxt;
      div        <= div_nxt;
      lock_cnt   <= lock_nxt;
      burst_cnt  <= burst_nxt;
      phase_cnt  <= phase_nxt;
      burst_done <= done_nxt;
      cmd_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tpm_nxt   = tpm_clk;
    div_nxt   = div;
    lock_nxt  = lock_cnt;
    burst_nxt = burst_cnt;
    phase_nxt = phase_cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_WAIT_LOCK: begin
        tpm_nxt   = 1'b0;
        phase_nxt = '0;
        if (!locked) begin
          lock_nxt = '0;
        end else if (lock_cnt == LCK_W'(LOCK_WAIT)) begin
          state_nxt = S_IDLE;
          lock_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt + LCK_W'(1);
        end
      end

      S_IDLE: begin
        tpm_nxt   = 1'b0;
        phase_nxt = '0;
        if (accept) begin
          case (cmd_op)
            OP_RUN:    state_nxt = S_RUN;
            OP_BURST: begin
              if (cmd_arg != '0) begin
                burst_nxt = cmd_arg;
                state_nxt = S_BURST;
              end else begin
                done_nxt = 1'b1;
              end
            end
            OP_SETDIV: div_nxt = cmd_arg[DIV_W-1:0];
            default:   ;
          endcase
        end
      end

      S_RUN: begin
        if (phase_end) begin
          tpm_nxt   = ~tpm_clk;
          phase_nxt = div;
        end else begin
          phase_nxt = phase_cnt - DIV_W'(1);
        end
        if (accept) begin
          case (cmd_op)
            OP_STOP: begin
              // Low phase, or a high phase ending right now: stop at once
              // without another rising edge. Otherwise finish the high phase.
              if (!tpm_clk || phase_end) begin
                state_nxt = S_IDLE;
                tpm_nxt   = 1'b0;
                phase_nxt = '0;
              end else begin
                state_nxt = S_STOPPING;
              end
            end
            OP_BURST, OP_SETDIV: err_nxt = 1'b1;
            default: ;
          endcase
        end
      end

      S_BURST: begin
        if (phase_end) begin
          tpm_nxt   = ~tpm_clk;
          phase_nxt = div;
          if (tpm_clk) begin
            if (burst_cnt == CNT_W'(1)) begin
              // Last falling edge: no trailing low phase is owed.
              state_nxt = S_IDLE;
              burst_nxt = '0;
              phase_nxt = '0;
              done_nxt  = 1'b1;
            end else begin
              burst_nxt = burst_cnt - CNT_W'(1);
            end
          end
        end else begin
          phase_nxt = phase_cnt - DIV_W'(1);
        end
      end

      S_STOPPING: begin
        if (phase_end) begin
          tpm_nxt   = 1'b0;
          phase_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          phase_nxt = phase_cnt - DIV_W'(1);
        end
      end

      default: begin
        state_nxt = S_WAIT_LOCK;
        tpm_nxt   = 1'b0;
      end
    endcase

    // Lock loss overrides everything except the stored divisor.
    if ((state != S_WAIT_LOCK) && !locked) begin
      state_nxt = S_WAIT_LOCK;
      tpm_nxt   = 1'b0;
      div_nxt   = div;
      lock_nxt  = '0;
      burst_nxt = '0;
      phase_nxt = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_tpm_clk_ctrl.sv
module tb_tpm_clk_ctrl;

  localparam int K_HI   = 0;  // falling edge, v1 = high length
  localparam int K_LO   = 1;  // rising edge within a sequence, v1 = low length
  localparam int K_ERR  = 2;
  localparam int K_DONE = 3;  // v1 = pulses, v2 = cycles from first rise

  localparam logic [1:0] OP_STOP   = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_BURST  = 2'd2;
  localparam logic [1:0] OP_SETDIV = 2'd3;

  typedef struct {
    int kind;
    int v1;
    int v2;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        locked;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        tpm_clk;
  logic        busy;
  logic        burst_done;
  logic        cmd_err;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  int  ecnt = 0;
  int  cyc = 0;
  int  rise_cyc = 0;
  int  fall_cyc = 0;
  int  first_cyc = 0;
  int  pulse_cnt = 0;
  logic prev_clk = 1'b0;
  logic mon_en = 1'b1;

  tpm_clk_ctrl #(
    .DIV_W(8),
    .CNT_W(16),
    .LOCK_WAIT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .locked(locked),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .tpm_clk(tpm_clk),
    .busy(busy),
    .burst_done(burst_done),
    .cmd_err(cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void push(input int k, input int a, input int b);
    ev_t e;
    e.kind = k;
    e.v1   = a;
    e.v2   = b;
    exp_q.push_back(e);
  endfunction

  function automatic void got(input int k, input int a, input int b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d v1=%0d v2=%0d expected none", k, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.v1 != a || e.v2 != b) begin
        errors++;
        $display("FAIL event actual kind=%0d v1=%0d v2=%0d expected kind=%0d v1=%0d v2=%0d",
                 k, a, b, e.kind, e.v1, e.v2);
      end
    end
  endfunction

  // Monitor: turns tpm_clk edges and pulses into events and scores them.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (tpm_clk && !prev_clk) begin
        if (pulse_cnt > 0) got(K_LO, cyc - fall_cyc, 0);
        else first_cyc = cyc;
        rise_cyc = cyc;
        pulse_cnt++;
      end
      if (!tpm_clk && prev_clk) begin
        got(K_HI, cyc - rise_cyc, 0);
        fall_cyc = cyc;
      end
      if (cmd_err) got(K_ERR, 0, 0);
      if (burst_done) got(K_DONE, pulse_cnt, (pulse_cnt > 0) ? cyc - first_cyc : 0);
      if (!busy) pulse_cnt = 0;
    end
    prev_clk = tpm_clk;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg, output int acc);
    logic rdy;
    acc = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int i = 0; i < 200; i++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        acc = ecnt;
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    chk("cmd_accepted", (acc >= 0) ? 1 : 0, 1);
  endtask

  task automatic wait_level(input logic v, input string name);
    int found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tpm_clk == v) begin
        found = 1;
        break;
      end
    end
    chk(name, found, 1);
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (cmd_ready) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a1;
    int a2;
    int seen;

    rst_n     = 1'b0;
    locked    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_STOP;
    cmd_arg   = '0;
    #1;
    chk("reset_tpm_clk", tpm_clk, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done_err", {30'd0, burst_done, cmd_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Lock wait with a drop at count 10.
    @(negedge clk);
    locked = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (cmd_ready) seen = 1;
    end
    chk("lock_no_early_ready", seen, 0);
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_ready(n);
    chk("lock_wait_edges", n, 17);

    // Burst: divisor 1, N=3, then BURST 0 held during the burst.
    send_cmd(OP_SETDIV, 16'd1, a1);
    push(K_HI, 2, 0); push(K_LO, 2, 0);
    push(K_HI, 2, 0); push(K_LO, 2, 0);
    push(K_HI, 2, 0); push(K_DONE, 3, 10);
    push(K_DONE, 0, 0);
    send_cmd(OP_BURST, 16'd3, a1);
    send_cmd(OP_BURST, 16'd0, a2);
    chk("burst_backtoback_accept", a2 - a1, 12);
    repeat (4) @(negedge clk);
    chk("burst_idle_busy", busy, 0);

    // Run/stop: STOP on the 2nd cycle of a high phase.
    send_cmd(OP_SETDIV, 16'd3, a1);
    push(K_HI, 4, 0);
    send_cmd(OP_RUN, 16'd0, a1);
    wait_level(1'b1, "run_first_high");
    chk("run_busy", busy, 1);
    send_cmd(OP_STOP, 16'd0, a1);
    repeat (12) @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_tpm_clk", tpm_clk, 0);

    // STOP held in IDLE: accepted every cycle, no effect.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_STOP;
    for (int i = 0; i < 4; i++) begin
      chk("stop_idle_ready", cmd_ready, 1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("stop_idle_busy", busy, 0);

    // SETDIV during RUN: rejected, period stays at divisor 3.
    push(K_ERR, 0, 0);
    push(K_HI, 4, 0); push(K_LO, 4, 0); push(K_HI, 4, 0);
    send_cmd(OP_RUN, 16'd0, a1);
    wait_level(1'b1, "err_first_high");
    send_cmd(OP_SETDIV, 16'd0, a1);
    wait_level(1'b0, "err_first_low");
    wait_level(1'b1, "err_second_high");
    wait_level(1'b0, "err_second_low");
    send_cmd(OP_STOP, 16'd0, a1);
    repeat (10) @(negedge clk);
    chk("err_stop_busy", busy, 0);

    // Lock loss during BURST 5 with divisor 0, after 2 pulses.
    send_cmd(OP_SETDIV, 16'd0, a1);
    push(K_HI, 1, 0); push(K_LO, 1, 0); push(K_HI, 1, 0);
    send_cmd(OP_BURST, 16'd5, a1);
    wait_level(1'b1, "ll_rise1");
    wait_level(1'b0, "ll_fall1");
    wait_level(1'b1, "ll_rise2");
    wait_level(1'b0, "ll_fall2");
    locked = 1'b0;
    @(negedge clk);
    chk("ll_tpm_clk", tpm_clk, 0);
    chk("ll_busy", busy, 0);
    chk("ll_ready", cmd_ready, 0);
    locked = 1'b1;
    wait_ready(n);
    chk("relock_edges", n, 17);
    push(K_HI, 1, 0); push(K_DONE, 1, 1);
    send_cmd(OP_BURST, 16'd1, a1);
    repeat (10) @(negedge clk);
    chk("events_pending", exp_q.size(), 0);

    // Asynchronous reset in the middle of RUN.
    mon_en = 1'b0;
    send_cmd(OP_RUN, 16'd0, a1);
    wait_level(1'b1, "rst_run_high");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tpm_clk", tpm_clk, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cmd_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
